tx_frame_sched: RTL

Frame-level sequencer for the OFDM transmit chain. It runs between the config inputs / mapper buffer and the scrambler→IFFT path.
- Decides, symbol by symbol, whether the IFFT is fed a preamble, data or null symbol.
- Generates per-subcarrier valid/sop/eop/index strobes.
- Latches modulation/SS/BW/data_off config only at frame boundaries and issues the frame-start pulse.

---
 rtl/tx_sched_pkg.sv | 34 +++
 rtl/tx_frame_sched_sym_slot_cnt.sv | 56 +++++
 rtl/tx_frame_sched.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_sched_pkg.sv
// Shared types and constants for the OFDM transmit frame sequencer.
package tx_sched_pkg;

  typedef enum logic [1:0] {
    SYM_NULL     = 2'd0,
    SYM_PREAMBLE = 2'd1,
    SYM_DATA     = 2'd2
  } sym_type_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRE    = 3'd1,
    S_WAIT_D = 3'd2,
    S_DATA   = 3'd3,
    S_GAP_W  = 3'd4,
    S_GAP    = 3'd5
  } sched_state_t;

  localparam logic [2:0] ST_IDLE   = S_IDLE;
  localparam logic [2:0] ST_PRE    = S_PRE;
  localparam logic [2:0] ST_WAIT_D = S_WAIT_D;
  localparam logic [2:0] ST_DATA   = S_DATA;
  localparam logic [2:0] ST_GAP_W  = S_GAP_W;
  localparam logic [2:0] ST_GAP    = S_GAP;

  localparam int M_W  = 3;
  localparam int SS_W = 4;
  localparam int BW_W = 3;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

endpackage

// File: rtl/tx_frame_sched_sym_slot_cnt.sv
// sym_slot_cnt: walks one OFDM symbol of pFFT_N subcarrier slots after a start pulse,
// with registered busy/sop/eop/index outputs and no bubbles inside a symbol.
module sym_slot_cnt #(
  parameter int pFFT_N = 1024,
  parameter int pIDX_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_sop,
  output logic              o_eop,
  output logic [pIDX_W-1:0] o_idx
);

  localparam logic [pIDX_W-1:0] LAST_IDX = pIDX_W'(pFFT_N - 1);

  logic              r_busy;
  logic              r_sop;
  logic              r_eop;
  logic [pIDX_W-1:0] r_idx;
  logic [pIDX_W-1:0] w_idx_nxt;

  assign w_idx_nxt = r_idx + {{(pIDX_W-1){1'b0}}, 1'b1};

  // A start may land on the eop cycle, giving back-to-back symbols.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_sop  <= 1'b0;
      r_eop  <= 1'b0;
      r_idx  <= {pIDX_W{1'b0}};
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_sop  <= 1'b1;
      r_eop  <= (LAST_IDX == {pIDX_W{1'b0}});
      r_idx  <= {pIDX_W{1'b0}};
    end else if (r_busy && !r_eop) begin
      r_busy <= 1'b1;
      r_sop  <= 1'b0;
      r_eop  <= (w_idx_nxt == LAST_IDX);
      r_idx  <= w_idx_nxt;
    end else begin
      r_busy <= 1'b0;
      r_sop  <= 1'b0;
      r_eop  <= 1'b0;
      r_idx  <= {pIDX_W{1'b0}};
    end
  end

  assign o_busy = r_busy;
  assign o_sop  = r_sop;
  assign o_eop  = r_eop;
  assign o_idx  = r_idx;

endmodule

// File: rtl/tx_frame_sched.sv
// tx_frame_sched: per-symbol preamble/data/null sequencing for the OFDM transmitter.
// Optional macro TX_UNDERRUN_NULL_EN: fill an unready data slot with a NULL symbol and count it.
module tx_frame_sched
  import tx_sched_pkg::*;
#(
  parameter int pFFT_N    = 1024,
  parameter int pIDX_W    = 10,
  parameter int pDATA_SYM = 14,
  parameter int pGAP_SYM  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [M_W-1:0]    index_M,
  input  logic [SS_W-1:0]   index_SS,
  input  logic [BW_W-1:0]   index_BW,
  input  logic              data_off,
  input  logic              ifft_ready,
  input  logic              data_rdy,
  output logic [M_W-1:0]    oindex_M,
  output logic [SS_W-1:0]   oindex_SS,
  output logic [BW_W-1:0]   oindex_BW,
  output logic              odata_off,
  output logic              osof,
  output logic              oval,
  output logic              osop,
  output logic              oeop,
  output logic [pIDX_W-1:0] osc_idx,
  output logic [1:0]        osym_type,
  output logic [7:0]        osym_cnt,
  output logic              odata_req,
  output logic              obusy,
  output logic [15:0]       ounderrun
);

  localparam logic [7:0] LAST_DATA = 8'(pDATA_SYM - 1);
  localparam logic [3:0] LAST_GAP  = 4'(pGAP_SYM - 1);

  logic [2:0]      r_state;
  logic [3:0]      r_gap_cnt;
  logic [7:0]      r_sym_cnt;
  logic [M_W-1:0]  r_M;
  logic [SS_W-1:0] r_SS;
  logic [BW_W-1:0] r_BW;
  logic            r_data_off;
  logic            r_sof;
  sym_type_t       r_sym_type;
  logic            r_data_req;
  logic            r_busy;

  logic              w_val;
  logic              w_sop;
  logic              w_eop;
  logic [pIDX_W-1:0] w_idx;
  logic              w_free;
  logic              w_sym_end;
  logic [2:0]        w_phase;
  logic [2:0]        w_nstate;
  logic              w_start;
  logic              w_sof;
  sym_type_t         w_type_nxt;
  logic              w_req_nxt;
`ifdef TX_UNDERRUN_NULL_EN
  logic              w_underrun;
  logic [15:0]       r_underrun;
`endif

  sym_slot_cnt #(
    .pFFT_N (pFFT_N),
    .pIDX_W (pIDX_W)
  ) u_slot (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .o_busy  (w_val),
    .o_sop   (w_sop),
    .o_eop   (w_eop),
    .o_idx   (w_idx)
  );

  assign w_sym_end = w_val & w_eop;
  assign w_free    = ~w_val | w_eop;

  // Phase the scheduler is in once the symbol ending this cycle is accounted for.
  always_comb begin
    w_phase = r_state;
    if (w_sym_end) begin
      case (r_state)
        ST_PRE:  w_phase = ST_WAIT_D;
        ST_DATA: begin
          if (r_sym_cnt == LAST_DATA) begin
            w_phase = (pGAP_SYM == 0) ? ST_IDLE : ST_GAP_W;
          end else begin
            w_phase = ST_WAIT_D;
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == LAST_GAP) begin
            w_phase = ST_IDLE;
          end else begin
            w_phase = ST_GAP_W;
          end
        end
        default: w_phase = ST_IDLE;
      endcase
    end else begin
      w_phase = r_state;
    end
  end

  // Decide whether a new symbol starts on the next edge and what kind it is.
  always_comb begin
    w_start    = 1'b0;
    w_sof      = 1'b0;
    w_nstate   = r_state;
    w_type_nxt = r_sym_type;
    w_req_nxt  = 1'b0;
`ifdef TX_UNDERRUN_NULL_EN
    w_underrun = 1'b0;
`endif
    if (w_free) begin
      case (w_phase)
        ST_IDLE: begin
          if (enable && ifft_ready) begin
            w_start    = 1'b1;
            w_sof      = 1'b1;
            w_nstate   = ST_PRE;
            w_type_nxt = SYM_PREAMBLE;
          end else begin
            w_nstate   = ST_IDLE;
          end
        end
        ST_WAIT_D: begin
          if (ifft_ready && (data_rdy || r_data_off)) begin
            w_start    = 1'b1;
            w_nstate   = ST_DATA;
            w_type_nxt = r_data_off ? SYM_NULL : SYM_DATA;
            w_req_nxt  = ~r_data_off;
`ifdef TX_UNDERRUN_NULL_EN
          end else if (ifft_ready) begin
            w_start    = 1'b1;
            w_nstate   = ST_DATA;
            w_type_nxt = SYM_NULL;
            w_underrun = 1'b1;
`endif
          end else begin
            w_nstate   = ST_WAIT_D;
          end
        end
        ST_GAP_W: begin
          if (ifft_ready) begin
            w_start    = 1'b1;
            w_nstate   = ST_GAP;
            w_type_nxt = SYM_NULL;
          end else begin
            w_nstate   = ST_GAP_W;
          end
        end
        default: w_nstate = ST_IDLE;
      endcase
    end else begin
      w_nstate = r_state;
    end
  end

  // Frame state, frame-latched config and per-symbol attributes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_gap_cnt  <= 4'd0;
      r_sym_cnt  <= 8'd0;
      r_M        <= {M_W{1'b0}};
      r_SS       <= {SS_W{1'b0}};
      r_BW       <= {BW_W{1'b0}};
      r_data_off <= 1'b0;
      r_sof      <= 1'b0;
      r_sym_type <= SYM_NULL;
      r_data_req <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_sof   <= w_sof;
      r_busy  <= (w_nstate != ST_IDLE);
      if (w_sof) begin
        r_M        <= index_M;
        r_SS       <= index_SS;
        r_BW       <= index_BW;
        r_data_off <= data_off;
      end
      if (w_start) begin
        r_sym_type <= w_type_nxt;
        r_data_req <= w_req_nxt;
      end else if (w_val && !w_eop) begin
        r_data_req <= r_data_req;
      end else begin
        r_data_req <= 1'b0;
      end
      // Data-slot numbering restarts when the preamble ends.
      if (w_sym_end && (r_state == ST_PRE)) begin
        r_sym_cnt <= 8'd0;
      end else if (w_sym_end && (r_state == ST_DATA)) begin
        r_sym_cnt <= r_sym_cnt + 8'd1;
      end
      if (w_sym_end && (r_state == ST_DATA)) begin
        r_gap_cnt <= 4'd0;
      end else if (w_sym_end && (r_state == ST_GAP)) begin
        r_gap_cnt <= r_gap_cnt + 4'd1;
      end
    end
  end

`ifdef TX_UNDERRUN_NULL_EN
  // Saturating count of data slots that went out as NULL for lack of mapper data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_underrun <= 16'd0;
    end else if (w_underrun) begin
      r_underrun <= sat_inc16(r_underrun);
    end else begin
      r_underrun <= r_underrun;
    end
  end
  assign ounderrun = r_underrun;
`else
  assign ounderrun = 16'd0;
`endif

  assign oindex_M  = r_M;
  assign oindex_SS = r_SS;
  assign oindex_BW = r_BW;
  assign odata_off = r_data_off;
  assign osof      = r_sof;
  assign oval      = w_val;
  assign osop      = w_sop;
  assign oeop      = w_eop;
  assign osc_idx   = w_idx;
  assign osym_type = r_sym_type;
  assign osym_cnt  = r_sym_cnt;
  assign odata_req = r_data_req;
  assign obusy     = r_busy;

endmodule
